conv_tile_rowgen: RTL
=====================

// Module: conv_tile_rowgen
// PURPOSE
//  Parametrised successor to the conv tile row-index generator. Given a tile
//  origin in output coordinates, it walks every kernel tap (kr,kc) of a KxK
//  window. For each of ROWS parallel output rows it emits the input row index,
//  plus one input column index, with per-lane padding flags. Sits between the
//  layer sequencer and the input-feature buffer address logic. Honours stall.
// PARAMETERS
//  AW    16  width of coordinate/dimension ports
//  ROWS  3   number of parallel output rows per tile (>=1)
//  KW    4   width of k, s, p config fields
// PORTS
//  clk        in   1          clock, rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  en         in   1          start pulse; sampled only in IDLE
//  stall      in   1          hold all state and outputs this cycle
//  ox_start   in   AW         tile origin, output column
//  oy_start   in   AW         tile origin, output row (lane r = oy_start+r)
//  ix, iy     in   AW         input feature-map width/height
//  k, s, p    in   KW         kernel size, stride, padding
//  row_y      out  ROWS*AW    lane r at [r*AW +: AW]; input row index
//  row_pad    out  ROWS       lane r index outside [0,iy-1]
//  col_x      out  AW         input column index for current tap
//  col_pad    out  1          col_x outside [0,ix-1]
//  kr, kc     out  KW each    current kernel row/col tap
//  out_valid  out  1          outputs hold a tap
//  busy       out  1          high in RUN
//  done       out  1          one-cycle pulse after last tap accepted
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; every output 0, including row_y,
//    row_pad, col_x, col_pad, kr, kc, out_valid, busy and done.
//  - All outputs are registered. Config is latched when en=1 in IDLE.
//    Ports may change afterwards without effect until the next start.
//  - FSM:
//    IDLE -> RUN on en=1 with k!=0.
//    IDLE -> DONE on en=1 with k==0; no valid taps are emitted.
//    RUN -> DONE when tap (k-1,k-1) is presented and stall=0.
//    DONE -> IDLE unconditionally; done=1 for exactly that cycle.
//  - Latency: en at edge t gives the first tap (0,0) at edge t+1, with
//    out_valid=1 and busy=1.
//  - Tap order: kc is the inner loop, kr the outer. kc wraps k-1 -> 0 with
//    kr+1. There are exactly k*k valid beats with stall=0.
//  - A tap is consumed on each RUN cycle with stall=0. When stall=1, every
//    register, including done, holds. Stall in IDLE or DONE has no effect.
//  - en in RUN or DONE is ignored; there is no restart mid-run.
//  - Arithmetic, signed, AW+KW+2 bits internal, no overflow for legal config:
//      yv_r = (oy_start+r)*s + kr - p
//      xv   = ox_start*s + kc - p
//    Bases are precomputed at start, so only adders are needed per tap.
//  - Pad rule: row_pad[r]=1 iff yv_r<0 or yv_r>=iy. When padded,
//    row_y lane = 0. The same rule applies to col_pad/col_x using ix.
//  - In IDLE and DONE: out_valid=0. row_y, col_x, kr, kc and the pad flags
//    hold their last values.
//  - Reset mid-RUN: immediate return to IDLE with all outputs 0; no done.
// TESTING
//  1 k=6,s=2,p=2,ox=oy=1,ix=iy=32,ROWS=3, en one cycle, no stall
//    -> first beat row_y={4,2,0}(lanes 2,1,0), col_x=0, no pads;
//       36 valid beats; last row_y={9,7,5}, col_x=5; done 1 cycle later.
//  2 Top pad: oy_start=0,k=6,s=2,p=2
//    -> lane0 row_pad=1 for kr=0,1 (yv=-2,-1);
//       kr=2 gives row_y lane0=0, pad=0; col_pad=1 for kc=0,1 when ox=0.
//  3 Bottom pad: iy=8,oy_start=3,k=3,s=2,p=1
//    -> lane2 yv=9+kr, row_pad[2]=1 on all taps;
//       lane1 yv=7+kr, pad only for kr>=1.
//  4 Stall pattern from case 1 (1,1,0,1,1,0 during RUN)
//    -> outputs frozen while stalled; still exactly 36 distinct beats;
//       done delayed by the stall count.
//  5 reset_n low at beat 10 of case 1, and en asserted mid-RUN
//    -> all outputs 0 immediately on reset; no done.
//       en during RUN has no effect.
//  6 k=0, en=1 -> no out_valid beat; done=1 at the next edge; IDLE after.

Source files
------------

// File: rtl/conv_tile_rowgen_if.sv
// Handshake/config bundle between the layer sequencer and the conv tile
// row generator.
interface conv_tile_rowgen_if #(
    parameter int AW   = 16,
    parameter int ROWS = 3,
    parameter int KW   = 4
);
    logic                 en;
    logic                 stall;
    logic [AW-1:0]        ox_start;
    logic [AW-1:0]        oy_start;
    logic [AW-1:0]        ix;
    logic [AW-1:0]        iy;
    logic [KW-1:0]        k;
    logic [KW-1:0]        s;
    logic [KW-1:0]        p;
    logic [ROWS*AW-1:0]   row_y;
    logic [ROWS-1:0]      row_pad;
    logic [AW-1:0]        col_x;
    logic                 col_pad;
    logic [KW-1:0]        kr;
    logic [KW-1:0]        kc;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output en, stall, ox_start, oy_start, ix, iy, k, s, p,
        input  row_y, row_pad, col_x, col_pad, kr, kc,
        input  out_valid, busy, done
    );

    modport slave (
        input  en, stall, ox_start, oy_start, ix, iy, k, s, p,
        output row_y, row_pad, col_x, col_pad, kr, kc,
        output out_valid, busy, done
    );
endinterface

// File: rtl/conv_tile_rowgen.sv
// Walks the KxK taps of a conv window for ROWS parallel output rows and
// emits padded input row/column indices for the feature buffer.
module conv_tile_rowgen #(
    parameter int AW   = 16,
    parameter int ROWS = 3,
    parameter int KW   = 4
) (
    input logic              clk,
    input logic              reset_n,
    conv_tile_rowgen_if.slave bus
);
    localparam int W = AW + KW + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [KW-1:0]          r_k;
    logic [KW-1:0]          r_kr;
    logic [KW-1:0]          r_kc;
    logic [AW-1:0]          r_ix;
    logic [AW-1:0]          r_iy;
    logic signed [W-1:0]    r_ybase [ROWS];
    logic signed [W-1:0]    r_xbase;
    logic [ROWS*AW-1:0]     r_row_y;
    logic [ROWS-1:0]        r_row_pad;
    logic [AW-1:0]          r_col_x;
    logic                   r_col_pad;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;

    logic signed [W-1:0]    w_s;
    logic signed [W-1:0]    w_p;
    logic signed [W-1:0]    w_ox;
    logic signed [W-1:0]    w_oy;
    logic signed [W-1:0]    w_xbase;
    logic signed [W-1:0]    w_ybase [ROWS];
    logic signed [W-1:0]    w_ysel [ROWS];
    logic signed [W-1:0]    w_yv [ROWS];
    logic signed [W-1:0]    w_xsel;
    logic signed [W-1:0]    w_xv;
    logic signed [W-1:0]    w_ylim;
    logic signed [W-1:0]    w_xlim;
    logic signed [W-1:0]    w_tr_ext;
    logic signed [W-1:0]    w_tc_ext;
    logic [KW-1:0]          w_kmax;
    logic [KW-1:0]          w_tr;
    logic [KW-1:0]          w_tc;
    logic                   w_idle;
    logic                   w_kc_wrap;
    logic                   w_last;
    logic [ROWS*AW-1:0]     w_row_y;
    logic [ROWS-1:0]        w_row_pad;
    logic [AW-1:0]          w_col_x;
    logic                   w_col_pad;

    // Bases are multiplied once from the ports at start; per tap only adds.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_s       = signed'({{(W-KW){1'b0}}, bus.s});
        w_p       = signed'({{(W-KW){1'b0}}, bus.p});
        w_ox      = signed'({{(W-AW){1'b0}}, bus.ox_start});
        w_oy      = signed'({{(W-AW){1'b0}}, bus.oy_start});
        w_xbase   = w_ox * w_s - w_p;
        for (int r = 0; r < ROWS; r++) begin
            w_ybase[r] = (w_oy + signed'(W'(r))) * w_s - w_p;
        end
        w_kmax    = r_k - 1'b1;
        w_kc_wrap = (r_kc == w_kmax);
        w_last    = w_kc_wrap && (r_kr == w_kmax);
        w_tr      = '0;
        w_tc      = '0;
        w_ysel    = w_ybase;
        w_xsel    = w_xbase;
        w_ylim    = signed'({{(W-AW){1'b0}}, bus.iy});
        w_xlim    = signed'({{(W-AW){1'b0}}, bus.ix});
        if (!w_idle) begin
            w_tc   = w_kc_wrap ? '0 : r_kc + 1'b1;
            w_tr   = w_kc_wrap ? r_kr + 1'b1 : r_kr;
            w_ysel = r_ybase;
            w_xsel = r_xbase;
            w_ylim = signed'({{(W-AW){1'b0}}, r_iy});
            w_xlim = signed'({{(W-AW){1'b0}}, r_ix});
        end
        w_tr_ext  = signed'({{(W-KW){1'b0}}, w_tr});
        w_tc_ext  = signed'({{(W-KW){1'b0}}, w_tc});
        w_row_y   = '0;
        w_row_pad = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_yv[r]      = w_ysel[r] + w_tr_ext;
            w_row_pad[r] = w_yv[r][W-1] || (w_yv[r] >= w_ylim);
            if (!w_row_pad[r]) begin
                w_row_y[r*AW +: AW] = w_yv[r][AW-1:0];
            end
        end
        w_xv      = w_xsel + w_tc_ext;
        w_col_pad = w_xv[W-1] || (w_xv >= w_xlim);
        w_col_x   = w_col_pad ? '0 : w_xv[AW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_kr      <= '0;
            r_kc      <= '0;
            r_ix      <= '0;
            r_iy      <= '0;
            r_xbase   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                r_ybase[r] <= '0;
            end
            r_row_y   <= '0;
            r_row_pad <= '0;
            r_col_x   <= '0;
            r_col_pad <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_k     <= bus.k;
                        r_ix    <= bus.ix;
                        r_iy    <= bus.iy;
                        r_ybase <= w_ybase;
                        r_xbase <= w_xbase;
                        if (bus.k != '0) begin
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_valid   <= 1'b1;
                            r_kr      <= w_tr;
                            r_kc      <= w_tc;
                            r_row_y   <= w_row_y;
                            r_row_pad <= w_row_pad;
                            r_col_x   <= w_col_x;
                            r_col_pad <= w_col_pad;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_kr      <= w_tr;
                            r_kc      <= w_tc;
                            r_row_y   <= w_row_y;
                            r_row_pad <= w_row_pad;
                            r_col_x   <= w_col_x;
                            r_col_pad <= w_col_pad;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row_y     = r_row_y;
    assign bus.row_pad   = r_row_pad;
    assign bus.col_x     = r_col_x;
    assign bus.col_pad   = r_col_pad;
    assign bus.kr        = r_kr;
    assign bus.kc        = r_kc;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
